// File: rtl/mem_bus_sequencer.sv
// -----------------------------------------------------------------------------
// mem_bus_sequencer
//
// Shares one external memory bus between the instruction-fetch requester (IF)
// and the data load/store requester (D). The memory has a fixed access
// latency of MEM_LATENCY cycles; the sequencer holds readM/writeM for that
// many cycles, captures read data on the last access cycle and then returns
// a one-cycle done pulse to the requester that owned the access.
//
// Transaction shape (one access):
//   IDLE   : request sampled, D has fixed priority over IF
//   ACCESS : MEM_LATENCY cycles, strobe + address driven, store data on bus
//   DONE   : strobes dropped, bus released
//   IDLE   : owner's done pulse visible; no new grant in this cycle, so a
//            requester that drops its request on seeing done is not re-granted
//
// Parameters:
//   WORD_SIZE    data/address width
//   MEM_LATENCY  cycles a strobe is held (1..15)
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   if_req, if_addr         fetch request (level) and address
//   if_rdata, if_done       fetched word and its one-cycle done pulse
//   d_req, d_we             data request (level), 1 = store / 0 = load
//   d_addr, d_wdata         data address and store data
//   d_rdata, d_done         load data and its one-cycle done pulse
//   readM, writeM, address  memory strobes and address (registered)
//   data                    bidirectional memory data bus, driven only while
//                           writeM is high
//   busy                    high whenever the FSM is not in IDLE
//
// Optional feature (macro MEM_BUS_STATS_EN):
//   if_count, d_count       completed-access counters, one increment per
//                           done pulse, wrapping at all-ones
// -----------------------------------------------------------------------------
module mem_bus_sequencer #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic [WORD_SIZE-1:0] if_rdata,
  output logic                 if_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 busy
`ifdef MEM_BUS_STATS_EN
  ,
  output logic [WORD_SIZE-1:0] if_count,
  output logic [WORD_SIZE-1:0] d_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Counter reload: ACCESS lasts cnt+1 cycles, so load latency minus one.
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t               state_r;
  state_t               next_state_s;

  // Latched transaction attributes.
  logic                 owner_d_r;
  logic                 we_r;
  logic [WORD_SIZE-1:0] wdata_r;
  logic [3:0]           cnt_r;

  // Registered outputs.
  logic                 readm_r;
  logic                 writem_r;
  logic [WORD_SIZE-1:0] address_r;
  logic [WORD_SIZE-1:0] if_rdata_r;
  logic [WORD_SIZE-1:0] d_rdata_r;
  logic                 if_done_r;
  logic                 d_done_r;
  logic                 busy_r;

  // Next values for the registered outputs.
  logic                 readm_nx_s;
  logic                 writem_nx_s;
  logic [WORD_SIZE-1:0] address_nx_s;
  logic [WORD_SIZE-1:0] if_rdata_nx_s;
  logic [WORD_SIZE-1:0] d_rdata_nx_s;
  logic                 if_done_nx_s;
  logic                 d_done_nx_s;
  logic                 busy_nx_s;

  logic                 grant_d_s;
  logic                 grant_if_s;
  logic                 done_hold_s;

  // The IDLE cycle that shows a done pulse never grants: the requester only
  // learns of completion in that cycle and needs one cycle to drop its req.
  assign done_hold_s = if_done_r | d_done_r;

  // Arbitration: D has fixed priority over IF, grants only from IDLE.
  always_comb begin
    grant_d_s  = 1'b0;
    grant_if_s = 1'b0;
    if ((state_r == ST_IDLE) && !done_hold_s) begin
      grant_d_s  = d_req;
      grant_if_s = !d_req && if_req;
    end else begin
      grant_d_s  = 1'b0;
      grant_if_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_d_s || grant_if_s) begin
          next_state_s = ST_ACCESS;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == 4'd0) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_ACCESS;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Transaction latch and latency counter; request inputs are only looked at
  // on the grant, later changes are ignored until the access completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_d_r <= 1'b0;
      we_r      <= 1'b0;
      wdata_r   <= '0;
      cnt_r     <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_d_s) begin
            owner_d_r <= 1'b1;
            we_r      <= d_we;
            wdata_r   <= d_wdata;
            cnt_r     <= CNT_LOAD;
          end else if (grant_if_s) begin
            owner_d_r <= 1'b0;
            we_r      <= 1'b0;
            cnt_r     <= CNT_LOAD;
          end
        end
        ST_ACCESS: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Output logic: next values of every registered output, chosen so the
  // strobes line up exactly with the ACCESS state.
  always_comb begin
    readm_nx_s    = 1'b0;
    writem_nx_s   = 1'b0;
    address_nx_s  = address_r;
    if_rdata_nx_s = if_rdata_r;
    d_rdata_nx_s  = d_rdata_r;
    if_done_nx_s  = 1'b0;
    d_done_nx_s   = 1'b0;
    busy_nx_s     = (next_state_s != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (grant_d_s) begin
          address_nx_s = d_addr;
          readm_nx_s   = !d_we;
          writem_nx_s  = d_we;
        end else if (grant_if_s) begin
          address_nx_s = if_addr;
          readm_nx_s   = 1'b1;
          writem_nx_s  = 1'b0;
        end else begin
          readm_nx_s  = 1'b0;
          writem_nx_s = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == 4'd0) begin
          // Last access cycle: memory data is valid now, capture for the owner.
          if (!we_r && owner_d_r) begin
            d_rdata_nx_s = data;
          end else if (!we_r) begin
            if_rdata_nx_s = data;
          end else begin
            d_rdata_nx_s = d_rdata_r;
          end
        end else begin
          readm_nx_s  = !we_r;
          writem_nx_s = we_r;
        end
      end
      ST_DONE: begin
        if_done_nx_s = !owner_d_r;
        d_done_nx_s  = owner_d_r;
      end
      default: begin
        busy_nx_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readm_r    <= 1'b0;
      writem_r   <= 1'b0;
      address_r  <= '0;
      if_rdata_r <= '0;
      d_rdata_r  <= '0;
      if_done_r  <= 1'b0;
      d_done_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      readm_r    <= readm_nx_s;
      writem_r   <= writem_nx_s;
      address_r  <= address_nx_s;
      if_rdata_r <= if_rdata_nx_s;
      d_rdata_r  <= d_rdata_nx_s;
      if_done_r  <= if_done_nx_s;
      d_done_r   <= d_done_nx_s;
      busy_r     <= busy_nx_s;
    end
  end

  assign readM    = readm_r;
  assign writeM   = writem_r;
  assign address  = address_r;
  assign if_rdata = if_rdata_r;
  assign d_rdata  = d_rdata_r;
  assign if_done  = if_done_r;
  assign d_done   = d_done_r;
  assign busy     = busy_r;

  // The bus is driven from the registered write strobe, so reset releases it
  // immediately together with writeM.
  assign data = writem_r ? wdata_r : {WORD_SIZE{1'bz}};

`ifdef MEM_BUS_STATS_EN
  logic [WORD_SIZE-1:0] if_count_r;
  logic [WORD_SIZE-1:0] d_count_r;

  // Completed-access counters, stepped together with the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_count_r <= '0;
      d_count_r  <= '0;
    end else begin
      if (if_done_nx_s) begin
        if_count_r <= if_count_r + {{(WORD_SIZE-1){1'b0}}, 1'b1};
      end
      if (d_done_nx_s) begin
        d_count_r <= d_count_r + {{(WORD_SIZE-1){1'b0}}, 1'b1};
      end
    end
  end

  assign if_count = if_count_r;
  assign d_count  = d_count_r;
`endif

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_sequencer
//
// Directed bench for mem_bus_sequencer. dut0 uses MEM_LATENCY=2 against a
// small memory model that only presents read data on the last strobe cycle
// and only commits a write at the end of the last strobe cycle. dut1 uses
// MEM_LATENCY=1 for back-to-back fetches. Cycle k below means the k-th
// negative clock edge after the cycle in which the request was raised.
// -----------------------------------------------------------------------------
module tb_mem_bus_sequencer;

  localparam int L0 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic [15:0] if_rdata, d_rdata, address;
  logic        if_done, d_done, readM, writeM, busy;
  wire  [15:0] data;

  logic        if_req1;
  logic [15:0] if_addr1;
  logic        d_req1, d_we1;
  logic [15:0] d_addr1, d_wdata1;
  logic [15:0] if_rdata1, d_rdata1, address1;
  logic        if_done1, d_done1, readM1, writeM1, busy1;
  wire  [15:0] data1;

`ifdef MEM_BUS_STATS_EN
  logic [15:0] if_count, d_count, if_count1, d_count1;
`endif

  int compared = 0;
  int mismatched = 0;

  // Memory model for dut0.
  logic [15:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;
  logic        probe_en;
  int          rd_cnt, wr_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= 0;
      wr_cnt <= 0;
    end else begin
      rd_cnt <= readM ? rd_cnt + 1 : 0;
      wr_cnt <= writeM ? wr_cnt + 1 : 0;
    end
  end

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (writeM && wr_cnt == L0 - 1) mem[address[7:0]] <= data;
  end

  // probe_en pulls a known pattern onto the bus to see whether it is released.
  assign data  = (readM && rd_cnt == L0 - 1) ? mem[address[7:0]] :
                 (probe_en ? 16'hA5C3 : 16'hzzzz);
  assign data1 = readM1 ? (address1 ^ 16'h5555) : 16'hzzzz;

  mem_bus_sequencer #(.WORD_SIZE(16), .MEM_LATENCY(2)) dut0 (
    .clk(clk), .reset(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .readM(readM), .writeM(writeM), .address(address), .data(data), .busy(busy)
`ifdef MEM_BUS_STATS_EN
    , .if_count(if_count), .d_count(d_count)
`endif
  );

  mem_bus_sequencer #(.WORD_SIZE(16), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_done(if_done1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_rdata(d_rdata1), .d_done(d_done1),
    .readM(readM1), .writeM(writeM1), .address(address1), .data(data1), .busy(busy1)
`ifdef MEM_BUS_STATS_EN
    , .if_count(if_count1), .d_count(d_count1)
`endif
  );

  task automatic preload(input logic [7:0] a, input logic [15:0] v);
    @(negedge clk);
    pre_addr = a;
    pre_data = v;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    compared++; if ({readM, writeM, if_done, d_done, busy} !== 5'b0) begin
      mismatched++; $display("FAIL reset_ctrl: got %b want 00000", {readM, writeM, if_done, d_done, busy});
    end
    compared++; if (address !== 16'h0000) begin
      mismatched++; $display("FAIL reset_address: got %h want 0000", address);
    end
    compared++; if ({if_rdata, d_rdata} !== 32'h0) begin
      mismatched++; $display("FAIL reset_rdata: got %h want 0", {if_rdata, d_rdata});
    end
    compared++; if ({readM1, busy1, if_done1} !== 3'b0) begin
      mismatched++; $display("FAIL reset_dut1: got %b want 000", {readM1, busy1, if_done1});
    end
    probe_en = 1'b1; #1;
    compared++; if (data !== 16'hA5C3) begin
      mismatched++; $display("FAIL reset_bus_released: got %h want a5c3", data);
    end
    probe_en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_fetch;
    logic e;
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0010;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      e = (k == 1) || (k == 2);
      compared++; if (readM !== e) begin
        mismatched++; $display("FAIL fetch_readM k=%0d: got %b want %b", k, readM, e);
      end
      if (e) begin
        compared++; if (address !== 16'h0010) begin
          mismatched++; $display("FAIL fetch_address k=%0d: got %h want 0010", k, address);
        end
      end
      e = (k == 4);
      compared++; if (if_done !== e || d_done !== 1'b0) begin
        mismatched++; $display("FAIL fetch_done k=%0d: got if=%b d=%b want if=%b d=0", k, if_done, d_done, e);
      end
      if (k == 4) begin
        compared++; if (if_rdata !== 16'h4A12) begin
          mismatched++; $display("FAIL fetch_rdata: got %h want 4a12", if_rdata);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_store;
    logic e;
    logic [15:0] ed;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0080; d_wdata = 16'hBEEF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      e = (k == 1) || (k == 2);
      compared++; if (writeM !== e || readM !== 1'b0) begin
        mismatched++; $display("FAIL store_strobes k=%0d: got w=%b r=%b want w=%b r=0", k, writeM, readM, e);
      end
      if (e) begin
        ed = 16'hBEEF;
        compared++; if (data !== ed) begin
          mismatched++; $display("FAIL store_data k=%0d: got %h want %h", k, data, ed);
        end
      end
      e = (k == 4);
      compared++; if (d_done !== e) begin
        mismatched++; $display("FAIL store_done k=%0d: got %b want %b", k, d_done, e);
      end
      if (k == 4) begin
        d_req = 1'b0; d_we = 1'b0;
      end
    end
    compared++; if (mem[8'h80] !== 16'hBEEF) begin
      mismatched++; $display("FAIL store_mem: got %h want beef", mem[8'h80]);
    end
    probe_en = 1'b1; #1;
    compared++; if (data !== 16'hA5C3) begin
      mismatched++; $display("FAIL store_bus_idle: got %h want a5c3", data);
    end
    probe_en = 1'b0;
  endtask

  task automatic test_simultaneous;
    logic e;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    if_req = 1'b1; if_addr = 16'h0030;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      e = (k == 4);
      compared++; if (d_done !== e) begin
        mismatched++; $display("FAIL sim_d_done k=%0d: got %b want %b", k, d_done, e);
      end
      e = (k == 9);
      compared++; if (if_done !== e) begin
        mismatched++; $display("FAIL sim_if_done k=%0d: got %b want %b", k, if_done, e);
      end
      e = (k == 1) || (k == 2) || (k == 6) || (k == 7);
      compared++; if (readM !== e || writeM !== 1'b0) begin
        mismatched++; $display("FAIL sim_strobes k=%0d: got r=%b w=%b want r=%b w=0", k, readM, writeM, e);
      end
      if (k == 4) begin
        compared++; if (d_rdata !== 16'h7E57 || if_rdata !== 16'h4A12) begin
          mismatched++; $display("FAIL sim_d_rdata: got d=%h if=%h want d=7e57 if=4a12", d_rdata, if_rdata);
        end
        d_req = 1'b0;
      end
      if (k == 9) begin
        compared++; if (if_rdata !== 16'h0C0D || d_rdata !== 16'h7E57) begin
          mismatched++; $display("FAIL sim_if_rdata: got if=%h d=%h want if=0c0d d=7e57", if_rdata, d_rdata);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid;
    logic e;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h5A5A;
    @(negedge clk);
    compared++; if (writeM !== 1'b1) begin
      mismatched++; $display("FAIL rmid_access: got writeM=%b want 1", writeM);
    end
    rst = 1'b1; probe_en = 1'b1; #1;
    compared++; if (writeM !== 1'b0 || busy !== 1'b0 || data !== 16'hA5C3) begin
      mismatched++; $display("FAIL rmid_async: got w=%b busy=%b data=%h want 0 0 a5c3", writeM, busy, data);
    end
    probe_en = 1'b0;
    @(negedge clk);
    compared++; if (d_done !== 1'b0 || mem[8'h40] !== 16'h1111) begin
      mismatched++; $display("FAIL rmid_nocommit: got done=%b mem=%h want 0 1111", d_done, mem[8'h40]);
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      e = (k == 1) || (k == 2);
      compared++; if (writeM !== e) begin
        mismatched++; $display("FAIL rmid_restart_w k=%0d: got %b want %b", k, writeM, e);
      end
      e = (k == 4);
      compared++; if (d_done !== e) begin
        mismatched++; $display("FAIL rmid_restart_done k=%0d: got %b want %b", k, d_done, e);
      end
      if (k == 4) begin
        d_req = 1'b0; d_we = 1'b0;
      end
    end
    compared++; if (mem[8'h40] !== 16'h5A5A) begin
      mismatched++; $display("FAIL rmid_mem: got %h want 5a5a", mem[8'h40]);
    end
  endtask

  task automatic test_back_to_back;
    logic e;
    @(negedge clk);
    if_req1 = 1'b1; if_addr1 = 16'h0050;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      e = (k % 4 == 1);
      compared++; if (readM1 !== e) begin
        mismatched++; $display("FAIL b2b_readM k=%0d: got %b want %b", k, readM1, e);
      end
      e = (k % 4 == 3);
      compared++; if (if_done1 !== e) begin
        mismatched++; $display("FAIL b2b_done k=%0d: got %b want %b", k, if_done1, e);
      end
      e = (k % 4 == 1) || (k % 4 == 2);
      compared++; if (busy1 !== e) begin
        mismatched++; $display("FAIL b2b_busy k=%0d: got %b want %b", k, busy1, e);
      end
      if (k % 4 == 3) begin
        compared++; if (if_rdata1 !== 16'h5505) begin
          mismatched++; $display("FAIL b2b_rdata k=%0d: got %h want 5505", k, if_rdata1);
        end
      end
    end
    if_req1 = 1'b0;
  endtask

`ifdef MEM_BUS_STATS_EN
  task automatic run_one(input logic is_d, input logic [15:0] a);
    logic got;
    got = 1'b0;
    @(negedge clk);
    if (is_d) begin d_req = 1'b1; d_we = 1'b0; d_addr = a; end
    else begin if_req = 1'b1; if_addr = a; end
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (if_done || d_done) begin
        got = 1'b1; if_req = 1'b0; d_req = 1'b0;
      end
    end
    compared++; if (!got) begin
      mismatched++; $display("FAIL stats_timeout: got no done want done");
      if_req = 1'b0; d_req = 1'b0;
    end
  endtask

  task automatic test_stats;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    run_one(1'b0, 16'h0010); run_one(1'b1, 16'h0020); run_one(1'b0, 16'h0010);
    run_one(1'b1, 16'h0080); run_one(1'b0, 16'h0030);
    repeat (2) @(negedge clk);
    compared++; if (if_count !== 16'd3 || d_count !== 16'd2) begin
      mismatched++; $display("FAIL stats_counts: got if=%0d d=%0d want 3 2", if_count, d_count);
    end
    force dut0.if_count_r = 16'hFFFF;
    @(negedge clk);
    release dut0.if_count_r;
    run_one(1'b0, 16'h0010);
    repeat (2) @(negedge clk);
    compared++; if (if_count !== 16'h0000) begin
      mismatched++; $display("FAIL stats_wrap: got %h want 0000", if_count);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = 16'h0000; d_req = 1'b0; d_we = 1'b0;
    d_addr = 16'h0000; d_wdata = 16'h0000;
    if_req1 = 1'b0; if_addr1 = 16'h0000; d_req1 = 1'b0; d_we1 = 1'b0;
    d_addr1 = 16'h0000; d_wdata1 = 16'h0000;
    pre_we = 1'b0; pre_addr = 8'h00; pre_data = 16'h0000; probe_en = 1'b0;
    preload(8'h10, 16'h4A12);
    preload(8'h20, 16'h7E57);
    preload(8'h30, 16'h0C0D);
    preload(8'h40, 16'h1111);
    test_reset();
    repeat (2) @(negedge clk);
    test_fetch();
    test_store();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
`ifdef MEM_BUS_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
